// File: rtl/gcm_pkg.sv
// Shared GCM/GHASH definitions: field width, reduction constant, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a.
//   GCM_BLK_W   : GHASH block width
//   GCM_R       : bit-reflected reduction constant for x^128+x^7+x^2+x+1
//   state_t     : GHASH engine FSM states
//   legal_digit : elaboration-time check of the digit width
package gcm_pkg;

    localparam int GCM_BLK_W = 128;
    localparam logic [GCM_BLK_W-1:0] GCM_R = 128'hE1000000_00000000_00000000_00000000;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

    // Only powers of two that divide the block width evenly are supported.
    function automatic logic legal_digit(input int w);
        return (w == 1) || (w == 2) || (w == 4) || (w == 8) ||
               (w == 16) || (w == 32) || (w == 64) || (w == 128);
    endfunction

endpackage

// File: rtl/gcm_gf128_digit.sv
// GF(2^128) digit step: consumes DIGIT_W multiplier bits (MSB first) of a shift-and-add multiply.
// Latency: combinational.
// Backpressure: none.
//   i_z    : running product in
//   i_v    : running multiplicand (H * x^k) in
//   i_bits : next DIGIT_W multiplier bits; i_bits[DIGIT_W-1] is consumed first
//   o_z    : running product out
//   o_v    : multiplicand out, advanced by DIGIT_W powers of x
module gcm_gf128_digit
    import gcm_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [GCM_BLK_W-1:0] i_z,
    input  logic [GCM_BLK_W-1:0] i_v,
    input  logic [DIGIT_W-1:0]   i_bits,
    output logic [GCM_BLK_W-1:0] o_z,
    output logic [GCM_BLK_W-1:0] o_v
);

    logic [GCM_BLK_W-1:0] w_z;
    logic [GCM_BLK_W-1:0] w_v;

    // Bit-reflected order: a right shift multiplies by x, and bit 0 falling
    // off the end is the x^128 term that folds back in via GCM_R.
    always_comb begin
        w_z = i_z;
        w_v = i_v;
        for (int j = 0; j < DIGIT_W; j++) begin
            if (i_bits[DIGIT_W-1-j]) begin
                w_z = w_z ^ w_v;
            end
            if (w_v[0]) begin
                w_v = (w_v >> 1) ^ GCM_R;
            end else begin
                w_v = w_v >> 1;
            end
        end
        o_z = w_z;
        o_v = w_v;
    end

endmodule

// File: rtl/gcm_ghash_ds.sv
// Digit-serial GHASH engine: Y <- (Y ^ X) * H over GF(2^128), DIGIT_W multiplier bits per cycle.
// Latency: CYCLES = 128/DIGIT_W cycles in MULT; result and y_valid appear CYCLES+1 cycles after next.
// Backpressure: ready=0 while multiplying; init/next presented then are ignored without side effects.
//   clk, reset_n : clock, async active-low reset
//   init, h0     : load H from h0 and clear Y (wins over a simultaneous next)
//   next, x      : start Y <- (Y ^ x) * H
//   y            : accumulator, only updated when a multiply completes
//   ready        : 1 = idle, commands accepted
//   y_valid      : 1-cycle pulse when a multiply result lands in y
module gcm_ghash_ds
    import gcm_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 init,
    input  logic                 next,
    input  logic [GCM_BLK_W-1:0] h0,
    input  logic [GCM_BLK_W-1:0] x,
    output logic [GCM_BLK_W-1:0] y,
    output logic                 ready,
    output logic                 y_valid
);

    localparam int CYCLES = GCM_BLK_W / DIGIT_W;
    localparam int CTR_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    if (!legal_digit(DIGIT_W)) begin : g_bad_digit
        $fatal(1, "gcm_ghash_ds: DIGIT_W must be a power of two from 1 to 128");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_start;
    logic                 w_last;
    logic [CTR_W-1:0]     r_ctr;
    logic [GCM_BLK_W-1:0] r_h;
    logic [GCM_BLK_W-1:0] r_y;
    logic [GCM_BLK_W-1:0] r_z;
    logic [GCM_BLK_W-1:0] r_v;
    logic [GCM_BLK_W-1:0] r_xs;
    logic                 r_y_valid;
    logic [GCM_BLK_W-1:0] w_z;
    logic [GCM_BLK_W-1:0] w_v;

    gcm_gf128_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .i_z    (r_z),
        .i_v    (r_v),
        .i_bits (r_xs[GCM_BLK_W-1 -: DIGIT_W]),
        .o_z    (w_z),
        .o_v    (w_v)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // init takes priority: a next arriving with it is dropped, not deferred.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (next && !init) begin
                    w_start     = 1'b1;
                    w_state_nxt = MULT;
                end
            end
            MULT: begin
                if (r_ctr == CTR_W'(CYCLES - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctr     <= '0;
            r_h       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_v       <= '0;
            r_xs      <= '0;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= w_last;
            if (r_state == IDLE && init) begin
                r_h <= h0;
                r_y <= '0;
            end
            if (w_start) begin
                r_z   <= '0;
                r_v   <= r_h;
                r_xs  <= r_y ^ x;
                r_ctr <= '0;
            end
            if (r_state == MULT) begin
                r_z   <= w_z;
                r_v   <= w_v;
                r_xs  <= r_xs << DIGIT_W;
                r_ctr <= r_ctr + CTR_W'(1);
                // y only ever sees the finished product
                if (w_last) begin
                    r_y <= w_z;
                end
            end
        end
    end

    assign y       = r_y;
    assign ready   = (r_state == IDLE);
    assign y_valid = r_y_valid;

endmodule

// File: tb/tb_gcm_ghash_ds.sv
// Self-checking bench for gcm_ghash_ds, one instance per digit width 1, 4, 8, 128.
// Each instance has its own stimulus process pushing expected results and a monitor popping them.
module tb_gcm_ghash_ds;

    typedef struct {
        logic [127:0] y;
        int           issue;
        string        nm;
    } exp_t;

    localparam logic [127:0] X1    = 128'h0123456789abcdef_fedcba9876543210;
    localparam logic [127:0] H_ONE = {1'b1, 127'b0};
    localparam logic [127:0] H_X   = {2'b01, 126'b0};
    localparam logic [127:0] RED   = {8'hE1, 120'b0};
    localparam logic [127:0] RED2  = {8'h70, 8'h80, 112'b0};
    localparam logic [127:0] NH    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] NC    = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] NY1   = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [127:0] NLEN  = 128'h00000000000000000000000000000080;
    localparam logic [127:0] NY2   = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp_v);
        end
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DW  = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 128;
        localparam int CYC = 128 / DW;

        logic         rst_n;
        logic         init_i;
        logic         next_i;
        logic [127:0] h0_i;
        logic [127:0] x_i;
        logic [127:0] y_o;
        logic         rdy_o;
        logic         yv_o;
        exp_t         q[$];
        logic [127:0] y_hold = '0;
        bit           prev_yv = 1'b0;
        string        pf;

        gcm_ghash_ds #(
            .DIGIT_W (DW)
        ) u_dut (
            .clk     (clk),
            .reset_n (rst_n),
            .init    (init_i),
            .next    (next_i),
            .h0      (h0_i),
            .x       (x_i),
            .y       (y_o),
            .ready   (rdy_o),
            .y_valid (yv_o)
        );

        task automatic wait_ready(input string nm);
            int n;
            @(negedge clk);
            n = 0;
            while (!rdy_o && n < CYC + 20) begin
                @(negedge clk);
                n++;
            end
            if (!rdy_o) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s ready timeout: ready=%0b required 1", nm, rdy_o);
            end
        endtask

        task automatic do_init(input logic [127:0] h, input string nm);
            wait_ready(nm);
            init_i = 1'b1;
            h0_i   = h;
            @(negedge clk);
            init_i = 1'b0;
        endtask

        task automatic do_next(input logic [127:0] xv, input logic [127:0] ey,
                               input bit push, input string nm);
            exp_t e;
            wait_ready(nm);
            next_i = 1'b1;
            x_i    = xv;
            if (push) begin
                e.y     = ey;
                e.issue = cyc;
                e.nm    = nm;
                q.push_back(e);
            end
            @(negedge clk);
            next_i = 1'b0;
        endtask

        // Monitor: result/latency against the queue, single-cycle y_valid,
        // and y frozen while a multiply runs.
        always @(negedge clk) begin
            exp_t e;
            if (!rst_n) begin
                prev_yv = 1'b0;
            end else begin
                if (yv_o) begin
                    chk({pf, " ready_with_y_valid"}, 128'(rdy_o), 128'd1);
                    chk({pf, " y_valid_pulse"}, 128'(prev_yv), 128'd0);
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL %s unexpected y_valid: y=%h with nothing pending", pf, y_o);
                    end else begin
                        e = q.pop_front();
                        chk({pf, " ", e.nm, " y"}, y_o, e.y);
                        chk({pf, " ", e.nm, " latency"}, 128'(cyc - e.issue), 128'(CYC + 1));
                    end
                end else if (!rdy_o) begin
                    chk({pf, " y_stable_in_mult"}, y_o, y_hold);
                end
                if (rdy_o) y_hold = y_o;
                prev_yv = yv_o;
            end
        end

        initial begin
            int n;
            pf     = $sformatf("DW%0d", DW);
            rst_n  = 1'b0;
            init_i = 1'b0;
            next_i = 1'b0;
            h0_i   = '0;
            x_i    = '0;
            repeat (3) @(negedge clk);
            chk({pf, " reset y"}, y_o, '0);
            chk({pf, " reset ready"}, 128'(rdy_o), 128'd1);
            chk({pf, " reset y_valid"}, 128'(yv_o), 128'd0);
            rst_n = 1'b1;
            @(negedge clk);
            chk({pf, " post_reset ready"}, 128'(rdy_o), 128'd1);

            // T1 identity
            do_init(H_ONE, "T1 init");
            do_next(X1, X1, 1'b1, "T1");

            // T2 reduction, init must clear the nonzero Y
            do_init(H_X, "T2 init");
            chk({pf, " T2 init clears y"}, y_o, '0);
            do_next(128'h1, RED, 1'b1, "T2a");
            do_next('0, RED2, 1'b1, "T2b");

            // T3 NIST TC2, chained straight into the length block (back-to-back)
            do_init(NH, "T3 init");
            do_next(NC, NY1, 1'b1, "T3");
            do_next(NLEN, NY2, 1'b1, "T5 chain");

            // T4 commands while busy are ignored
            do_init(H_ONE, "T4 init");
            do_next(X1, X1, 1'b1, "T4a");
            chk({pf, " T4 busy"}, 128'(rdy_o), 128'd0);
            init_i = 1'b1;
            next_i = 1'b1;
            h0_i   = NH;
            x_i    = NC;
            @(negedge clk);
            init_i = 1'b0;
            next_i = 1'b0;
            do_next('0, X1, 1'b1, "T4b H kept");

            // T5 init+next collision: init applies, next dropped
            wait_ready("T5 coll");
            init_i = 1'b1;
            next_i = 1'b1;
            h0_i   = H_X;
            x_i    = X1;
            @(negedge clk);
            init_i = 1'b0;
            next_i = 1'b0;
            chk({pf, " T5 coll y"}, y_o, '0);
            chk({pf, " T5 coll ready"}, 128'(rdy_o), 128'd1);
            chk({pf, " T5 coll y_valid"}, 128'(yv_o), 128'd0);
            do_next(128'h1, RED, 1'b1, "T5 after coll");

            // T6 reset in the middle of a multiply
            do_init(H_ONE, "T6 init");
            do_next(X1, '0, 1'b0, "T6 aborted");
            repeat (CYC / 2) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk({pf, " T6 reset y"}, y_o, '0);
            chk({pf, " T6 reset ready"}, 128'(rdy_o), 128'd1);
            chk({pf, " T6 reset y_valid"}, 128'(yv_o), 128'd0);
            @(negedge clk);
            rst_n = 1'b1;
            do_next(X1, '0, 1'b1, "T6 H cleared");
            do_init(NH, "T6 init2");
            do_next(NC, NY1, 1'b1, "T6 NIST");

            n = 0;
            while (q.size() != 0 && n < 3 * CYC + 20) begin
                @(negedge clk);
                n++;
            end
            chk({pf, " results outstanding"}, 128'(q.size()), 128'd0);
            n_done++;
        end
    end

    initial begin
        while (n_done < 4 && cyc < 60000) @(negedge clk);
        if (n_done < 4) begin
            n_tests++;
            n_fail++;
            $display("FAIL global timeout: %0d of 4 instances finished", n_done);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
